// File: rtl/key_sched_inv.sv
// Inverse AES-128 key schedule: walks from the round-10 key back to the cipher key,
// presenting one round key per valid/ready handshake.

module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);
    // Forward S-box flattened MSB-first: entry 0 sits in bits [2047:2040].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] idx;

    assign idx     = {~byte_val, 3'b000};
    assign sub_val = SBOX[idx +: 8];
endmodule

module key_sched_inv (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         busy,
    output logic         done
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   load_init, load_prev, finish;

    // Handshake: a key transfers on any rising edge where key_valid and key_ready are
    // both high; while key_valid is high and key_ready is low, key_out and round_out
    // are frozen, and key_valid never drops without a transfer (except on reset).
    logic handshake;
    assign handshake = key_valid & key_ready;

    // Previous-round key derivation from the current key words w4..w7.
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0] rot_w3, sub_w3;
    logic [7:0]  rcon;

    assign w4 = key_out[127:96];
    assign w5 = key_out[95:64];
    assign w6 = key_out[63:32];
    assign w7 = key_out[31:0];

    assign w3     = w7 ^ w6;
    assign w2     = w6 ^ w5;
    assign w1     = w5 ^ w4;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sbox u_sbox0 (.byte_val(rot_w3[31:24]), .sub_val(sub_w3[31:24]));
    aes_sbox u_sbox1 (.byte_val(rot_w3[23:16]), .sub_val(sub_w3[23:16]));
    aes_sbox u_sbox2 (.byte_val(rot_w3[15:8]),  .sub_val(sub_w3[15:8]));
    aes_sbox u_sbox3 (.byte_val(rot_w3[7:0]),   .sub_val(sub_w3[7:0]));

    always_comb begin
        rcon = 8'h00;
        case (round_out)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0 = w4 ^ sub_w3 ^ {rcon, 24'h000000};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_init = 1'b0;
        load_prev = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_init = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    if (round_out == 4'd0) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        load_prev = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_out   <= '0;
            round_out <= 4'd0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (load_init) begin
                key_out   <= key_in;
                round_out <= 4'd10;
                key_valid <= 1'b1;
            end else if (load_prev) begin
                key_out   <= {w0, w1, w2, w3};
                round_out <= round_out - 4'd1;
            end
            if (finish) key_valid <= 1'b0;
        end
    end

    assign busy = (state == RUN);
endmodule

// File: tb/tb_key_sched_inv.sv
// Directed bench for key_sched_inv using the FIPS-197 A.1 and C.1 AES-128 schedules.

module tb_key_sched_inv;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    // FIPS-197 A.1 expansion of 2b7e151628aed2a6abf7158809cf4f3c, indexed by round.
    logic [127:0] fips_keys [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] C1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_R0  = 128'h000102030405060708090a0b0c0d0e0f;

    // Observed bundle: {key_valid, busy, done, round_out, key_out}.
    logic [134:0] obs;
    assign obs = {key_valid, busy, done, round_out, key_out};

    key_sched_inv dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_out   (key_out),
        .round_out (round_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0t want earlier finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [134:0] exp;
        rst = 1'b1; start = 1'b1; key_in = fips_keys[10]; key_ready = 1'b1;
        step();
        step();
        exp = '0;
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", obs, exp);
        end
        rst = 1'b0; start = 1'b0;
        step();
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_idle_hold: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_fips();
        logic [134:0] exp;
        key_in = fips_keys[10]; start = 1'b1; key_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            exp = {3'b110, 4'(r), fips_keys[r]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL fips_round%0d: got %h want %h", r, obs, exp);
            end
            step();
        end
        exp = {3'b001, 4'd0, fips_keys[0]};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL fips_done: got %h want %h", obs, exp);
        end
        step();
        exp = {3'b000, 4'd0, fips_keys[0]};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL fips_idle_hold: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [134:0] exp;
        logic         rdy;
        int           r;
        bit           fin;
        r = 10; fin = 1'b0;
        key_in = fips_keys[10]; start = 1'b1; key_ready = 1'b0;
        step();
        start = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            exp = {3'b110, 4'(r), fips_keys[r]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL bp_cycle%0d_round%0d: got %h want %h", c, r, obs, exp);
            end
            rdy = 1'($urandom_range(0, 1));
            key_ready = rdy;
            step();
            if (rdy) begin
                if (r == 0) fin = 1'b1;
                else        r--;
            end
        end
        n_cmp++;
        if (!fin) begin
            n_err++;
            $display("FAIL bp_timeout: got round %0d want all 11 keys accepted", r);
        end
        exp = {3'b001, 4'd0, fips_keys[0]};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL bp_done: got %h want %h", obs, exp);
        end
        key_ready = 1'b1;
        step();
    endtask

    task automatic test_start_during_run();
        logic [134:0] exp;
        key_in = fips_keys[10]; start = 1'b1; key_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            exp = {3'b110, 4'(r), fips_keys[r]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL sdr_round%0d: got %h want %h", r, obs, exp);
            end
            if (r == 5) begin
                start  = 1'b1;
                key_in = C1_R10;
            end else begin
                start = 1'b0;
            end
            step();
        end
        exp = {3'b001, 4'd0, fips_keys[0]};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL sdr_done: got %h want %h", obs, exp);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [134:0] exp;
        key_in = fips_keys[10]; start = 1'b1; key_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 4; r--) begin
            exp = {3'b110, 4'(r), fips_keys[r]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rmr_round%0d: got %h want %h", r, obs, exp);
            end
            if (r == 4) rst = 1'b1;
            step();
        end
        exp = '0;
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rmr_reset: got %h want %h", obs, exp);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rmr_no_done: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [134:0] exp;
        logic [6:0]   ctl;
        key_in = fips_keys[10]; start = 1'b1; key_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) step();
        exp = {3'b001, 4'd0, fips_keys[0]};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_first_done: got %h want %h", obs, exp);
        end
        key_in = C1_R10; start = 1'b1;
        step();
        start = 1'b0;
        exp = {3'b110, 4'd10, C1_R10};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_first_key: got %h want %h", obs, exp);
        end
        for (int r = 9; r >= 0; r--) begin
            step();
            ctl = {key_valid, busy, done, round_out};
            n_cmp++;
            if (ctl !== {3'b110, 4'(r)}) begin
                n_err++;
                $display("FAIL b2b_round%0d: got %h want %h", r, ctl, {3'b110, 4'(r)});
            end
        end
        n_cmp++;
        if (key_out !== C1_R0) begin
            n_err++;
            $display("FAIL b2b_round0_key: got %h want %h", key_out, C1_R0);
        end
        step();
        exp = {3'b001, 4'd0, C1_R0};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_second_done: got %h want %h", obs, exp);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_in = '0; key_ready = 1'b0;
        test_reset();
        test_fips();
        test_backpressure();
        test_start_during_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
